// File: rtl/scc_cfg_master.sv
// SCC serial configuration master: single local-bus requests shifted out over CFGCLK/CFGLOAD pins.
// Define SCC_MASTER_VERIFY_EN to enable automatic write-then-readback verification.
module scc_cfg_master #(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned RD_LSB_FIRST = 1
) (
    input  logic              hclk_i,
    input  logic              hreset_i,
    input  logic              req_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              verify_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [DATA_W-1:0] rdata_o,
    input  logic              ncfgrst_i,
    output logic              cfgclk_o,
    output logic              cfgload_o,
    output logic              cfgwnr_o,
    output logic              cfgdatain_o,
    input  logic              cfgdataout_i
);
    localparam int unsigned MaxAd = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned MaxW  = (MaxAd > CLK_DIV) ? MaxAd : CLK_DIV;
    localparam int unsigned CW    = $clog2(MaxW) + 1;
    localparam logic [CW-1:0] SetupLast = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DivHalf   = CW'(CLK_DIV);
    localparam logic [CW-1:0] DivLast   = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] AddrLast  = CW'(ADDR_W - 1);
    localparam logic [CW-1:0] DataLast  = CW'(DATA_W - 1);

    typedef enum logic [2:0] {
        StIdle, StSetup, StAddr, StWdata, StLoad, StRdata, StDone
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       div_q, div_d, div_inc, bit_q, bit_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_sh_q, addr_sh_d;
    logic [DATA_W-1:0]   wd_sh_q, wd_sh_d, rd_sh_q, rd_sh_d, rdata_q, rdata_d;
    logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                cfgclk_q, cfgclk_d, cfgload_q, cfgload_d;
    logic                cfgwnr_q, cfgwnr_d, cfgdatain_q, cfgdatain_d;
    logic [1:0]          rst_sync_q, dout_sync_q;
    logic                cfg_ok, dout_s, slot_end;
`ifdef SCC_MASTER_VERIFY_EN
    logic                verify_q, verify_d;
`else
    logic                unused_verify;
    assign unused_verify = verify_i;
`endif

    assign cfg_ok   = rst_sync_q[1];
    assign dout_s   = dout_sync_q[1];
    assign slot_end = (div_q == DivLast);
    assign div_inc  = slot_end ? '0 : div_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        write_d   = write_q;
        addr_sh_d = addr_sh_q;
        wd_sh_d   = wd_sh_q;
        rd_sh_d   = rd_sh_q;
        rdata_d   = rdata_q;
        err_d     = 1'b0;
        cfgwnr_d  = cfgwnr_q;
`ifdef SCC_MASTER_VERIFY_EN
        verify_d  = verify_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (req_i && cfg_ok) begin
                    state_d   = StSetup;
                    div_d     = '0;
                    bit_d     = '0;
                    write_d   = write_i;
                    addr_sh_d = addr_i;
                    wd_sh_d   = wdata_i;
`ifdef SCC_MASTER_VERIFY_EN
                    verify_d  = write_i & verify_i;
`endif
                end
            end
            StSetup: begin
                div_d = div_q + 1'b1;
                if (div_q == SetupLast) begin
                    state_d = StAddr;
                    div_d   = '0;
                end
            end
            StAddr: begin
                div_d = div_inc;
                if (slot_end) begin
                    // Rotate so the address is intact again for a readback pass.
                    addr_sh_d = (addr_sh_q << 1) | (addr_sh_q >> (ADDR_W - 1));
                    bit_d     = bit_q + 1'b1;
                    if (bit_q == AddrLast) begin
                        bit_d   = '0;
                        state_d = write_q ? StWdata : StLoad;
                    end
                end
            end
            StWdata: begin
                div_d = div_inc;
                if (slot_end) begin
                    wd_sh_d = (wd_sh_q << 1) | (wd_sh_q >> (DATA_W - 1));
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == DataLast) begin
                        bit_d   = '0;
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                div_d = div_inc;
                if (slot_end) begin
                    if (!write_q) begin
                        state_d = StRdata;
`ifdef SCC_MASTER_VERIFY_EN
                    end else if (verify_q) begin
                        state_d = StSetup;
                        write_d = 1'b0;
`endif
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRdata: begin
                div_d = div_inc;
                if (slot_end) begin
                    if (RD_LSB_FIRST != 0) begin
                        rd_sh_d = (rd_sh_q >> 1) | (DATA_W'(dout_s) << (DATA_W - 1));
                    end else begin
                        rd_sh_d = (rd_sh_q << 1) | DATA_W'(dout_s);
                    end
                    bit_d = bit_q + 1'b1;
                    if (bit_q == DataLast) begin
                        state_d = StDone;
                        rdata_d = rd_sh_d;
`ifdef SCC_MASTER_VERIFY_EN
                        err_d   = verify_q && (rd_sh_d != wd_sh_q);
`endif
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // SCC dropped out of reset mid-transaction: abandon and report.
        if (busy_q && !cfg_ok) begin
            state_d = StDone;
            err_d   = 1'b1;
            rdata_d = rdata_q;
        end

        if (state_d == StSetup) cfgwnr_d = write_d;
        busy_d      = !(state_d == StIdle || state_d == StDone);
        done_d      = (state_d == StDone);
        cfgclk_d    = (state_d inside {StAddr, StWdata, StLoad, StRdata}) && (div_d >= DivHalf);
        cfgload_d   = (state_d == StLoad);
        cfgdatain_d = (state_d == StAddr)  ? addr_sh_d[ADDR_W-1] :
                      (state_d == StWdata) ? wd_sh_d[DATA_W-1]   : 1'b0;
    end

    always_ff @(posedge hclk_i or posedge hreset_i) begin
        if (hreset_i) begin
            state_q     <= StIdle;
            div_q       <= '0;
            bit_q       <= '0;
            write_q     <= 1'b0;
            addr_sh_q   <= '0;
            wd_sh_q     <= '0;
            rd_sh_q     <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cfgclk_q    <= 1'b0;
            cfgload_q   <= 1'b0;
            cfgwnr_q    <= 1'b0;
            cfgdatain_q <= 1'b0;
            rst_sync_q  <= 2'b00;
            dout_sync_q <= 2'b00;
`ifdef SCC_MASTER_VERIFY_EN
            verify_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            write_q     <= write_d;
            addr_sh_q   <= addr_sh_d;
            wd_sh_q     <= wd_sh_d;
            rd_sh_q     <= rd_sh_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cfgclk_q    <= cfgclk_d;
            cfgload_q   <= cfgload_d;
            cfgwnr_q    <= cfgwnr_d;
            cfgdatain_q <= cfgdatain_d;
            rst_sync_q  <= {rst_sync_q[0], ncfgrst_i};
            dout_sync_q <= {dout_sync_q[0], cfgdataout_i};
`ifdef SCC_MASTER_VERIFY_EN
            verify_q    <= verify_d;
`endif
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign cfgclk_o    = cfgclk_q;
    assign cfgload_o   = cfgload_q;
    assign cfgwnr_o    = cfgwnr_q;
    assign cfgdatain_o = cfgdatain_q;

endmodule

// File: tb/tb_scc_cfg_master.sv
// Bench for scc_cfg_master: default instance (LSB-first reads) and a narrow MSB-first instance,
// each with a behavioural SCC responder on the serial pins.
module tb_scc_cfg_master;
    logic hclk = 1'b0;
    logic hreset, ncfgrst;
    always #5 hclk = ~hclk;

    // Default instance
    logic        req0, write0, verify0, busy0, done0, err0;
    logic [11:0] addr0;
    logic [31:0] wdata0, rdata0, mdata0;
    logic        cfgclk0, cfgload0, cfgwnr0, cfgdatain0, dout0;

    // ADDR_W=8, DATA_W=16, CLK_DIV=6, MSB-first instance
    logic        req1, write1, busy1, done1, err1;
    logic [7:0]  addr1;
    logic [15:0] wdata1, rdata1, mdata1;
    logic        cfgclk1, cfgload1, cfgwnr1, cfgdatain1, dout1;

    scc_cfg_master dut0 (
        .hclk_i(hclk), .hreset_i(hreset), .req_i(req0), .write_i(write0), .addr_i(addr0),
        .wdata_i(wdata0), .verify_i(verify0), .busy_o(busy0), .done_o(done0), .err_o(err0),
        .rdata_o(rdata0), .ncfgrst_i(ncfgrst), .cfgclk_o(cfgclk0), .cfgload_o(cfgload0),
        .cfgwnr_o(cfgwnr0), .cfgdatain_o(cfgdatain0), .cfgdataout_i(dout0)
    );

    scc_cfg_master #(.ADDR_W(8), .DATA_W(16), .CLK_DIV(6), .RD_LSB_FIRST(0)) dut1 (
        .hclk_i(hclk), .hreset_i(hreset), .req_i(req1), .write_i(write1), .addr_i(addr1),
        .wdata_i(wdata1), .verify_i(1'b0), .busy_o(busy1), .done_o(done1), .err_o(err1),
        .rdata_o(rdata1), .ncfgrst_i(ncfgrst), .cfgclk_o(cfgclk1), .cfgload_o(cfgload1),
        .cfgwnr_o(cfgwnr1), .cfgdatain_o(cfgdatain1), .cfgdataout_i(dout1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // SCC model, default instance: logs rising-CFGCLK bits, replays mdata0 bit0 first.
    logic [63:0] cap0 = '0;
    int capn0 = 0, ldc0 = 0, idx0 = 0, done_cnt0 = 0;
    logic rd_on0 = 1'b0, clk_p0 = 1'b0, ld_p0 = 1'b0;
    always @(negedge hclk) begin
        if (cfgclk0 && !clk_p0) begin
            cap0 = {cap0[62:0], cfgdatain0};
            capn0++;
        end
        if (cfgload0) ldc0++;
        if (done0) done_cnt0++;
        if (ld_p0 && !cfgload0 && !cfgwnr0) begin
            rd_on0 = 1'b1;
            idx0   = 0;
        end else if (rd_on0 && clk_p0 && !cfgclk0) begin
            idx0++;
        end
        if (done0 || hreset) rd_on0 = 1'b0;
        dout0  = (rd_on0 && idx0 < 32) ? mdata0[idx0] : 1'b0;
        clk_p0 = cfgclk0;
        ld_p0  = cfgload0;
    end

    // SCC model, narrow instance: replays mdata1 MSB first; tracks CFGCLK rise spacing.
    logic [63:0] cap1 = '0;
    int capn1 = 0, idx1 = 0, ncyc1 = 0, lr1 = 0, pr1 = 0;
    logic rd_on1 = 1'b0, clk_p1 = 1'b0, ld_p1 = 1'b0;
    always @(negedge hclk) begin
        ncyc1++;
        if (cfgclk1 && !clk_p1) begin
            cap1 = {cap1[62:0], cfgdatain1};
            capn1++;
            pr1 = lr1;
            lr1 = ncyc1;
        end
        if (ld_p1 && !cfgload1 && !cfgwnr1) begin
            rd_on1 = 1'b1;
            idx1   = 0;
        end else if (rd_on1 && clk_p1 && !cfgclk1) begin
            idx1++;
        end
        if (done1 || hreset) rd_on1 = 1'b0;
        dout1  = (rd_on1 && idx1 < 16) ? mdata1[15 - idx1] : 1'b0;
        clk_p1 = cfgclk1;
        ld_p1  = cfgload1;
    end

    task automatic wait_done0(input int budget, output int lat);
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge hclk); #1;
            if (done0) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run0(input logic w, input logic v, input logic [11:0] a, input logic [31:0] d,
                        output int lat);
        @(negedge hclk);
        write0 = w; verify0 = v; addr0 = a; wdata0 = d; req0 = 1'b1;
        @(posedge hclk); #1;
        req0 = 1'b0;
        wait_done0(1000, lat);
    endtask

    task automatic run1(input logic w, input logic [7:0] a, input logic [15:0] d, output int lat);
        @(negedge hclk);
        write1 = w; addr1 = a; wdata1 = d; req1 = 1'b1;
        @(posedge hclk); #1;
        req1 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 1000; k++) begin
            @(posedge hclk); #1;
            if (done1) begin
                lat = k;
                break;
            end
        end
    endtask

    typedef struct {
        logic        write;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] mdata;
        logic [31:0] exp_rdata;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vec[5];
        int lat, c0, l0, dc, k;
        logic [63:0] expc;
        logic seen;

        vec[0] = '{1'b1, 12'hCCC, 32'hCCCC_CCCC, 32'h0,         32'h0};
        vec[1] = '{1'b0, 12'h123, 32'h0,         32'hA5A5_0F0F, 32'hA5A5_0F0F};
        vec[2] = '{1'b1, 12'h001, 32'h8000_0001, 32'h0,         32'hA5A5_0F0F};
        vec[3] = '{1'b0, 12'hFFF, 32'h0,         32'h1234_5678, 32'h1234_5678};
        vec[4] = '{1'b0, 12'h800, 32'h0,         32'hFFFF_FFFE, 32'hFFFF_FFFE};

        hreset = 1'b1; ncfgrst = 1'b1;
        req0 = 0; write0 = 0; verify0 = 0; addr0 = '0; wdata0 = '0; mdata0 = '0;
        req1 = 0; write1 = 0; addr1 = '0; wdata1 = '0; mdata1 = '0;
        repeat (3) @(posedge hclk); #1;
        chk("reset_outs0", {busy0, done0, err0, cfgclk0, cfgload0, cfgwnr0, cfgdatain0}, 0);
        chk("reset_rdata0", rdata0, 0);
        chk("reset_outs1", {busy1, done1, err1, cfgclk1, cfgload1, cfgwnr1, cfgdatain1}, 0);
        @(negedge hclk); hreset = 1'b0;
        repeat (4) @(posedge hclk);

        for (int i = 0; i < 5; i++) begin
            mdata0 = vec[i].mdata;
            c0 = capn0; l0 = ldc0;
            run0(vec[i].write, 1'b0, vec[i].addr, vec[i].wdata, lat);
            expc = (64'(vec[i].addr) << 33) | (vec[i].write ? (64'(vec[i].wdata) << 1) : 64'h0);
            chk($sformatf("v%0d_latency", i), lat, 364);
            chk($sformatf("v%0d_err", i), err0, 0);
            chk($sformatf("v%0d_rdata", i), rdata0, vec[i].exp_rdata);
            chk($sformatf("v%0d_pins_idle", i), {busy0, cfgclk0, cfgload0, cfgdatain0}, 0);
            chk($sformatf("v%0d_wnr", i), cfgwnr0, vec[i].write);
            chk($sformatf("v%0d_rises", i), capn0 - c0, 45);
            chk($sformatf("v%0d_serial", i), cap0[44:0], expc[44:0]);
            chk($sformatf("v%0d_load_cycles", i), ldc0 - l0, 8);
            @(posedge hclk); #1;
            chk($sformatf("v%0d_done_pulse", i), done0, 0);
        end

        // Abort a read in its 10th data slot.
        mdata0 = 32'h1357_2468;
        @(negedge hclk);
        write0 = 1'b0; addr0 = 12'h456; req0 = 1'b1;
        @(posedge hclk); #1;
        req0 = 1'b0;
        repeat (183) @(posedge hclk);
        #1 ncfgrst = 1'b0;
        wait_done0(3, lat);
        chk("abort_done_within_3", lat, 3);
        chk("abort_err", err0, 1);
        chk("abort_rdata_kept", rdata0, 32'hFFFF_FFFE);
        chk("abort_pins_idle", {busy0, cfgclk0, cfgload0, cfgdatain0}, 0);
        @(negedge hclk); ncfgrst = 1'b1;
        repeat (4) @(posedge hclk);

        // REQ while SCC held in reset stays pending.
        @(negedge hclk); ncfgrst = 1'b0;
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        write0 = 1'b1; addr0 = 12'h0AA; wdata0 = 32'h5555_AAAA; req0 = 1'b1;
        seen = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(posedge hclk); #1;
            if (busy0) seen = 1'b1;
        end
        chk("pending_not_accepted", seen, 0);
        @(negedge hclk); ncfgrst = 1'b1;
        k = -1;
        for (int j = 1; j <= 6; j++) begin
            @(posedge hclk); #1;
            if (busy0) begin
                k = j;
                break;
            end
        end
        req0 = 1'b0;
        chk("pending_accept_edge", k, 3);
        wait_done0(1000, lat);
        chk("pending_latency", lat, 364);

        // REQ held through BUSY and the DONE cycle: exactly two back-to-back writes.
        @(posedge hclk);
        @(negedge hclk);
        dc = done_cnt0;
        write0 = 1'b1; addr0 = 12'h3C3; wdata0 = 32'hDEAD_BEEF; req0 = 1'b1;
        @(posedge hclk); #1;
        chk("b2b_first_busy", busy0, 1);
        wait_done0(1000, lat);
        chk("b2b_first_latency", lat, 364);
        @(posedge hclk); #1;
        chk("b2b_second_busy", busy0, 1);
        req0 = 1'b0;
        wait_done0(1000, lat);
        chk("b2b_second_latency", lat, 364);
        repeat (400) @(posedge hclk);
        #1 chk("b2b_done_count", done_cnt0 - dc, 2);

`ifdef SCC_MASTER_VERIFY_EN
        dc = done_cnt0;
        mdata0 = 32'h0F0F_0F0F;
        run0(1'b1, 1'b1, 12'h0A5, 32'h0F0F_0F0F, lat);
        chk("verify_ok_latency", lat, 728);
        chk("verify_ok_err", err0, 0);
        chk("verify_ok_rdata", rdata0, 32'h0F0F_0F0F);
        @(posedge hclk); #1;
        chk("verify_ok_single_done", done_cnt0 - dc, 1);
        mdata0 = 32'hF0F0_F0E0;
        run0(1'b1, 1'b1, 12'h0A5, 32'hF0F0_F0F0, lat);
        chk("verify_stuck_latency", lat, 728);
        chk("verify_stuck_err", err0, 1);
        chk("verify_stuck_rdata", rdata0, 32'hF0F0_F0E0);
`else
        dc = done_cnt0;
        run0(1'b1, 1'b1, 12'h0A5, 32'h0F0F_0F0F, lat);
        chk("verify_ignored_latency", lat, 364);
        chk("verify_ignored_err", err0, 0);
        chk("verify_ignored_rdata", rdata0, 32'hFFFF_FFFE);
        @(posedge hclk); #1;
        chk("verify_ignored_single_done", done_cnt0 - dc, 1);
`endif

        // Narrow instance: write then MSB-first read.
        c0 = capn1;
        run1(1'b1, 8'h5A, 16'hBEEF, lat);
        chk("p_write_latency", lat, 306);
        chk("p_write_rises", capn1 - c0, 25);
        chk("p_write_serial", cap1[24:0], {8'h5A, 16'hBEEF, 1'b0});
        chk("p_cfgclk_period", lr1 - pr1, 12);
        chk("p_write_wnr_err", {cfgwnr1, err1}, 2'b10);
        chk("p_write_rdata_kept", rdata1, 0);
        mdata1 = 16'hC3A1;
        run1(1'b0, 8'h3C, 16'h0, lat);
        chk("p_read_latency", lat, 306);
        chk("p_read_rdata", rdata1, 16'hC3A1);
        chk("p_read_wnr_err", {cfgwnr1, err1}, 2'b00);

        // HRESET in the middle of a write: immediate reset values, no DONE.
        @(negedge hclk);
        dc = done_cnt0;
        write0 = 1'b1; addr0 = 12'h777; wdata0 = 32'h1234_ABCD; req0 = 1'b1;
        @(posedge hclk); #1;
        req0 = 1'b0;
        repeat (100) @(posedge hclk);
        #2 hreset = 1'b1;
        #1 chk("hreset_outs", {busy0, done0, err0, cfgclk0, cfgload0, cfgwnr0, cfgdatain0}, 0);
        chk("hreset_rdata", rdata0, 0);
        repeat (3) @(posedge hclk);
        @(negedge hclk); hreset = 1'b0;
        repeat (400) @(posedge hclk);
        #1 chk("hreset_no_done", done_cnt0 - dc, 0);
        chk("hreset_idle", busy0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
